// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for lock, and qualifies it over a stable window
// before it releases the mic-capture reset. Defining PLL_SEQ_AUTORECOVER_EN makes FAULT retry by itself after a timeout.
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 48,
  parameter int unsigned LOCK_STABLE_CYCLES  = 4800,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 480000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       mic_rst_n_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABILIZE  = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             pll_rst_q, pll_rst_d;
  logic             mic_rst_n_q, mic_rst_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  assign locked_s = sync_q[1];

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart_i) begin
      state_d = RESET_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        RESET_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = RESET_HOLD;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d = RESET_HOLD;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        FAULT: begin
`ifdef PLL_SEQ_AUTORECOVER_EN
          if (cnt_q == TIMEOUT_LAST) begin
            state_d = RESET_HOLD;
            cnt_d   = '0;
            retry_d = '0;
          end
`else
          cnt_d = '0;
`endif
        end
        default: begin
          state_d = RESET_HOLD;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    pll_rst_d   = (state_d == RESET_HOLD) || (state_d == FAULT);
    mic_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
`ifdef PLL_SEQ_AUTORECOVER_EN
    if (state_d == FAULT)                  fault_d = 1'b1;
    else if (restart_i || state_d == RUN)  fault_d = 1'b0;
    else                                   fault_d = fault_q;
`else
    fault_d = (state_d == FAULT);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RESET_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      mic_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync_q      <= {sync_q[0], pll_locked_i};
      pll_rst_q   <= pll_rst_d;
      mic_rst_n_q <= mic_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign mic_rst_n_o     = mic_rst_n_q;
  assign ready_o         = ready_q;
  assign fault_o         = fault_q;
  assign retry_cnt_o     = retry_q;
  assign lock_loss_cnt_o = loss_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short cycle parameters; edge numbers in comments
// count rising edges after reset_n is released.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pll_locked_i;
  logic       restart_i;
  logic       pll_rst_o;
  logic       mic_rst_n_o;
  logic       ready_o;
  logic       fault_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;
  logic [2:0] state_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2),
    .CNT_W              (20)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked_i   (pll_locked_i),
    .restart_i      (restart_i),
    .pll_rst_o      (pll_rst_o),
    .mic_rst_n_o    (mic_rst_n_o),
    .ready_o        (ready_o),
    .fault_o        (fault_o),
    .retry_cnt_o    (retry_cnt_o),
    .lock_loss_cnt_o(lock_loss_cnt_o),
    .state_o        (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    pll_locked_i = 1'b0;
    restart_i    = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  // From RUN: drop lock (mic reset 3 edges later), re-lock right away, back in RUN 13 edges after that.
  task automatic lose_and_recover();
    pll_locked_i = 1'b0;
    tick(3);
    pll_locked_i = 1'b1;
    tick(13);
  endtask

  initial begin
    do_reset();
    reset_n = 1'b0;
    tick(1);
    check("rst_state", state_o, 0);
    check("rst_pll_rst", pll_rst_o, 1);
    check("rst_mic", mic_rst_n_o, 0);
    check("rst_ready", ready_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_retry", retry_cnt_o, 0);
    check("rst_loss", lock_loss_cnt_o, 0);

    // Bring-up: lock first sampled at edge 10.
    reset_n = 1'b1;
    tick(3);                                   // edge 3
    check("bu_pll_rst_e3", pll_rst_o, 1);
    check("bu_state_e3", state_o, 0);
    tick(1);                                   // edge 4
    check("bu_pll_rst_e4", pll_rst_o, 0);
    check("bu_state_e4", state_o, 1);
    tick(5);                                   // edge 9
    pll_locked_i = 1'b1;
    tick(2);                                   // edge 11
    check("bu_state_e11", state_o, 1);
    tick(1);                                   // edge 12
    check("bu_state_e12", state_o, 2);
    tick(7);                                   // edge 19
    check("bu_ready_e19", ready_o, 0);
    tick(1);                                   // edge 20
    check("bu_ready_e20", ready_o, 1);
    check("bu_mic_e20", mic_rst_n_o, 1);
    check("bu_state_e20", state_o, 3);
    check("bu_retry", retry_cnt_o, 0);

    // Lock loss in RUN: locked first sampled 0 at L1.
    pll_locked_i = 1'b0;
    tick(2);                                   // L2
    check("ll_mic_l2", mic_rst_n_o, 1);
    check("ll_ready_l2", ready_o, 1);
    tick(1);                                   // L3
    check("ll_mic_l3", mic_rst_n_o, 0);
    check("ll_ready_l3", ready_o, 0);
    check("ll_state_l3", state_o, 0);
    check("ll_loss_l3", lock_loss_cnt_o, 1);
    pll_locked_i = 1'b1;
    tick(12);                                  // L15
    check("ll_ready_l15", ready_o, 0);
    tick(1);                                   // L16
    check("ll_ready_l16", ready_o, 1);

    // Restart arriving on the same edge the FSM sees lock loss: counter must not move.
    pll_locked_i = 1'b0;
    tick(2);
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
    check("rs_coin_state", state_o, 0);
    check("rs_coin_loss", lock_loss_cnt_o, 1);
    pll_locked_i = 1'b1;
    tick(13);
    check("rs_coin_ready", ready_o, 1);

    // Saturation of the lock-loss counter.
    for (int i = 2; i <= 256; i++) begin
      lose_and_recover();
      if (i == 254) check("sat_loss_254", lock_loss_cnt_o, 254);
      if (i == 255) check("sat_loss_255", lock_loss_cnt_o, 255);
    end
    check("sat_loss_256", lock_loss_cnt_o, 255);
    check("sat_state", state_o, 3);

    do_reset();
    tick(1);
    check("rst2_loss", lock_loss_cnt_o, 0);

    // Glitch in STABILIZE: lock sampled 1 at edge 10, 0 at edge 17 only.
    do_reset();
    tick(9);                                   // edge 9
    pll_locked_i = 1'b1;
    tick(7);                                   // edge 16
    pll_locked_i = 1'b0;
    tick(1);                                   // edge 17
    pll_locked_i = 1'b1;
    tick(1);                                   // edge 18
    check("gl_state_e18", state_o, 2);
    tick(1);                                   // edge 19
    check("gl_state_e19", state_o, 1);
    check("gl_ready_e19", ready_o, 0);
    tick(1);                                   // edge 20
    check("gl_state_e20", state_o, 2);
    tick(7);                                   // edge 27
    check("gl_ready_e27", ready_o, 0);
    tick(1);                                   // edge 28
    check("gl_ready_e28", ready_o, 1);

    // Never locks: timeouts at edges 36, 72, FAULT at 108.
    do_reset();
    tick(35);
    check("nl_state_e35", state_o, 1);
    check("nl_retry_e35", retry_cnt_o, 0);
    tick(1);                                   // edge 36
    check("nl_state_e36", state_o, 0);
    check("nl_retry_e36", retry_cnt_o, 1);
    check("nl_pll_rst_e36", pll_rst_o, 1);
    tick(36);                                  // edge 72
    check("nl_retry_e72", retry_cnt_o, 2);
    check("nl_state_e72", state_o, 0);
    tick(35);                                  // edge 107
    check("nl_state_e107", state_o, 1);
    check("nl_fault_e107", fault_o, 0);
    tick(1);                                   // edge 108
    check("nl_state_e108", state_o, 4);
    check("nl_fault_e108", fault_o, 1);
    check("nl_pll_rst_e108", pll_rst_o, 1);
    check("nl_retry_e108", retry_cnt_o, 2);
    check("nl_mic_e108", mic_rst_n_o, 0);
`ifdef PLL_SEQ_AUTORECOVER_EN
    tick(31);                                  // edge 139
    check("ar_state_e139", state_o, 4);
    tick(1);                                   // edge 140
    check("ar_state_e140", state_o, 0);
    check("ar_fault_e140", fault_o, 1);
    check("ar_retry_e140", retry_cnt_o, 0);
    do_reset();
    tick(108);
    check("ar_refault", state_o, 4);
`else
    tick(1000);
    check("sticky_state", state_o, 4);
    check("sticky_fault", fault_o, 1);
`endif

    // Restart from FAULT with lock present.
    pll_locked_i = 1'b1;
    restart_i    = 1'b1;
    tick(1);                                   // E0
    restart_i = 1'b0;
    check("rf_state", state_o, 0);
    check("rf_fault", fault_o, 0);
    check("rf_retry", retry_cnt_o, 0);
    check("rf_pll_rst", pll_rst_o, 1);
    tick(5);                                   // E5
    check("rf_state_e5", state_o, 2);
    tick(7);                                   // E12
    check("rf_ready_e12", ready_o, 0);
    tick(1);                                   // E13
    check("rf_ready_e13", ready_o, 1);
    check("rf_fault_e13", fault_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
